// File: rtl/rng_guess_checker.sv
// Game-round controller: latches an RNG set, derives three targets (rng ^ key) and
// walks the player through three guesses with a life budget and a per-guess timeout.
module rng_guess_checker #(
  parameter int WIDTH   = 4,
  parameter int LIVES   = 3,
  parameter int TIMEOUT = 50_000_000,
  localparam int LW     = $clog2(LIVES + 1),
  localparam int TW     = $clog2(TIMEOUT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             enter,
  input  logic [WIDTH-1:0] guess,
  input  logic [WIDTH-1:0] rng_1,
  input  logic [WIDTH-1:0] rng_2,
  input  logic [WIDTH-1:0] rng_3,
  input  logic [WIDTH-1:0] key,
  output logic             load_rng,
  output logic [1:0]       stage,
  output logic [LW-1:0]    lives_left,
  output logic             miss,
  output logic             busy,
  output logic             win,
  output logic             lose
);

  typedef enum logic [2:0] {IDLE, LOAD, CAPTURE, GUESS, WIN, LOSE} state_e;

  state_e                  state_q, state_d;
  logic [1:0]              stage_q, stage_d;
  logic [LW-1:0]           lives_q, lives_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic [2:0][WIDTH-1:0]   tgt_q, tgt_d, rng_v;
  logic [WIDTH-1:0]        cur_tgt;
  logic                    miss_d;
  logic                    load_q, miss_q, busy_q, win_q, lose_q;

  assign rng_v = {rng_3, rng_2, rng_1};

  always_comb begin
    case (stage_q)
      2'd0:    cur_tgt = tgt_q[0];
      2'd1:    cur_tgt = tgt_q[1];
      default: cur_tgt = tgt_q[2];
    endcase
  end

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    lives_d = lives_q;
    timer_d = timer_q;
    tgt_d   = tgt_q;
    miss_d  = 1'b0;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD: begin
        lives_d = LW'(LIVES);
        stage_d = 2'd0;
        state_d = CAPTURE;
      end
      CAPTURE: begin
        for (int n = 0; n < 3; n++) tgt_d[n] = rng_v[n] ^ key;
        timer_d = '0;
        state_d = GUESS;
      end
      GUESS: begin
        timer_d = timer_q + TW'(1);
        // A submitted guess is evaluated instead of a simultaneous timeout.
        if (enter && guess == cur_tgt) begin
          stage_d = stage_q + 2'd1;
          timer_d = '0;
          if (stage_q == 2'd2) state_d = WIN;
        end else if (enter || timer_q == TW'(TIMEOUT - 1)) begin
          miss_d  = 1'b1;
          timer_d = '0;
          if (lives_q != '0)       lives_d = lives_q - LW'(1);
          if (lives_q <= LW'(1))   state_d = LOSE;
        end
      end
      WIN, LOSE: if (start) state_d = LOAD;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      stage_q <= '0;
      lives_q <= '0;
      timer_q <= '0;
      tgt_q   <= '0;
      load_q  <= 1'b0;
      miss_q  <= 1'b0;
      busy_q  <= 1'b0;
      win_q   <= 1'b0;
      lose_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      lives_q <= lives_d;
      timer_q <= timer_d;
      tgt_q   <= tgt_d;
      // Flag outputs are registered from the next state so they align with it.
      load_q  <= (state_d == LOAD);
      miss_q  <= miss_d;
      busy_q  <= (state_d == LOAD) || (state_d == CAPTURE) || (state_d == GUESS);
      win_q   <= (state_d == WIN);
      lose_q  <= (state_d == LOSE);
    end
  end

  assign load_rng   = load_q;
  assign stage      = stage_q;
  assign lives_left = lives_q;
  assign miss       = miss_q;
  assign busy       = busy_q;
  assign win        = win_q;
  assign lose       = lose_q;

endmodule

// File: tb/tb_rng_guess_checker.sv
// Bench for rng_guess_checker: round-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_rng_guess_checker;
  localparam int WIDTH = 4, LIVES = 3, TIMEOUT = 8;
  localparam int LW = $clog2(LIVES + 1);

  logic clk, rst, start, enter;
  logic [WIDTH-1:0] guess, rng_1, rng_2, rng_3, key;
  logic load_rng, miss, busy, win, lose;
  logic [1:0] stage;
  logic [LW-1:0] lives_left;

  int errors = 0, checks = 0, miss_cnt = 0, m_base = 0;

  rng_guess_checker #(.WIDTH(WIDTH), .LIVES(LIVES), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .enter(enter), .guess(guess),
    .rng_1(rng_1), .rng_2(rng_2), .rng_3(rng_3), .key(key),
    .load_rng(load_rng), .stage(stage), .lives_left(lives_left), .miss(miss),
    .busy(busy), .win(win), .lose(lose));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Round model: age counts setup cycles since a start (1 = load, 2 = capture, 3 = guessing);
  // over is 0 while playing, 1 after a win, 2 after a loss.
  int m_age = 0, m_over = 0, m_solved = 0, m_lives = 0, m_tmr = 0, m_miss = 0;
  int m_tgt[3] = '{0, 0, 0};

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      m_miss = 0;
      if (!rst) begin
        m_age = 0; m_over = 0; m_solved = 0; m_lives = 0; m_tmr = 0;
        m_tgt = '{0, 0, 0};
      end else if (m_age == 0 || m_over != 0) begin
        if (start) begin m_age = 1; m_over = 0; end
      end else if (m_age == 1) begin
        m_age = 2; m_lives = LIVES; m_solved = 0;
      end else if (m_age == 2) begin
        m_age = 3; m_tmr = 0;
        m_tgt[0] = int'(rng_1 ^ key); m_tgt[1] = int'(rng_2 ^ key); m_tgt[2] = int'(rng_3 ^ key);
      end else begin
        if (enter && int'(guess) == m_tgt[m_solved]) begin
          m_solved++; m_tmr = 0;
          if (m_solved == 3) m_over = 1;
        end else if (enter || m_tmr == TIMEOUT - 1) begin
          m_miss = 1; m_tmr = 0;
          if (m_lives > 0) m_lives--;
          if (m_lives == 0) m_over = 2;
        end else m_tmr++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("m_load",  int'(load_rng),   int'(m_age == 1 && m_over == 0));
      chk("m_busy",  int'(busy),       int'(m_age >= 1 && m_over == 0));
      chk("m_win",   int'(win),        int'(m_over == 1));
      chk("m_lose",  int'(lose),       int'(m_over == 2));
      chk("m_miss",  int'(miss),       m_miss);
      chk("m_stage", int'(stage),      m_solved);
      chk("m_lives", int'(lives_left), m_lives);
      if (miss === 1'b1) miss_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1; @(negedge clk); start = 0;
  endtask

  task automatic do_enter(input logic [WIDTH-1:0] g);
    guess = g; enter = 1; @(negedge clk); enter = 0;
  endtask

  task automatic set_rng(input logic [WIDTH-1:0] a, b, c, k);
    rng_1 = a; rng_2 = b; rng_3 = c; key = k;
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_load"}, int'(load_rng), 0);
    chk({tag, "_stage"}, int'(stage), 0);
    chk({tag, "_lives"}, int'(lives_left), 0);
    chk({tag, "_miss"}, int'(miss), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_win"}, int'(win), 0);
    chk({tag, "_lose"}, int'(lose), 0);
  endtask

  initial begin
    rst = 0; start = 0; enter = 0; guess = 0;
    set_rng(0, 0, 0, 0);
    tick(2);
    all_zero("reset_hold");
    #2 rst = 1;
    tick(1);
    do_enter(4'h0);
    chk("idle_enter_busy", int'(busy), 0);

    // Win: targets 6, C, 9
    set_rng(4'h3, 4'h9, 4'hC, 4'h5);
    m_base = miss_cnt;
    pulse_start();
    chk("start_load", int'(load_rng), 1);
    chk("start_busy", int'(busy), 1);
    tick(1);
    chk("load_one_cycle", int'(load_rng), 0);
    chk("load_lives", int'(lives_left), 3);
    tick(1);
    set_rng(4'h0, 4'h0, 4'h0, 4'hF);
    do_enter(4'h6);
    chk("win_stage1", int'(stage), 1);
    pulse_start();
    chk("guess_start_ignored", int'(load_rng), 0);
    chk("guess_start_stage", int'(stage), 1);
    do_enter(4'hC);
    chk("win_stage2", int'(stage), 2);
    do_enter(4'h9);
    chk("win_stage3", int'(stage), 3);
    chk("win_flag", int'(win), 1);
    chk("win_lives", int'(lives_left), 3);
    chk("win_no_miss", miss_cnt - m_base, 0);
    tick(3);
    chk("win_held", int'(win), 1);

    // Replay from WIN, then lose: targets 1, 2, 3
    set_rng(4'h1, 4'h2, 4'h3, 4'h0);
    pulse_start();
    chk("replay_win_clear", int'(win), 0);
    chk("replay_load", int'(load_rng), 1);
    tick(1);
    chk("replay_lives", int'(lives_left), 3);
    chk("replay_stage", int'(stage), 0);
    tick(1);
    m_base = miss_cnt;
    do_enter(4'h0);
    chk("lose_miss1", int'(miss), 1);
    chk("lose_lives2", int'(lives_left), 2);
    do_enter(4'h0);
    chk("lose_lives1", int'(lives_left), 1);
    do_enter(4'h0);
    chk("lose_lives0", int'(lives_left), 0);
    chk("lose_flag", int'(lose), 1);
    chk("lose_stage", int'(stage), 0);
    chk("lose_miss_count", miss_cnt - m_base, 3);
    do_enter(4'h0);
    chk("lose_no_underflow", int'(lives_left), 0);

    // Timeout: targets 3, 5, 7
    set_rng(4'h2, 4'h4, 4'h6, 4'h1);
    pulse_start();
    tick(2);
    tick(7);
    chk("to_before", int'(miss), 0);
    tick(1);
    chk("to_miss1", int'(miss), 1);
    chk("to_lives2", int'(lives_left), 2);
    tick(7);
    chk("to_restart", int'(miss), 0);
    tick(1);
    chk("to_miss2", int'(miss), 1);
    chk("to_lives1", int'(lives_left), 1);
    tick(7);
    do_enter(4'h3);
    chk("to_enter_wins_stage", int'(stage), 1);
    chk("to_enter_wins_miss", int'(miss), 0);
    chk("to_enter_wins_lives", int'(lives_left), 1);
    do_enter(4'h0);
    chk("to_lose", int'(lose), 1);

    // Reset mid-GUESS with two lives left
    pulse_start();
    tick(2);
    do_enter(4'h0);
    chk("rst_pre_lives", int'(lives_left), 2);
    tick(1);
    #2 rst = 0;
    #1 all_zero("reset_async");
    tick(2);
    all_zero("reset_low");
    #2 rst = 1;
    tick(2);
    all_zero("reset_release");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
